// File: rtl/grid_path_gen.sv
// Command encoder for the grid_walk receiver: walks a tracked 16x16 position to a latched
// target by emitting {dis,dir} move commands, each framed by a rotation_event strobe.
module grid_path_gen #(
    parameter int HOLD = 1,
    parameter int GAP  = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] target_x_i,
    input  logic [3:0] target_y_i,
    output logic [3:0] y_o,
    output logic       rotation_event_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] pos_x_o,
    output logic [3:0] pos_y_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CALC     = 3'd1,
        S_PULSE_HI = 3'd2,
        S_PULSE_LO = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);

    state_t     state_q, state_d;
    logic [3:0] tx_q, tx_d;
    logic [3:0] ty_q, ty_d;
    logic [3:0] pos_x_q, pos_x_d;
    logic [3:0] pos_y_q, pos_y_d;
    logic [3:0] y_q, y_d;
    logic [7:0] cnt_q, cnt_d;
    logic       re_q, re_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] dx_s;
    logic [3:0] dy_s;
    logic [3:0] cmd_s;

    // Step length is the remaining distance capped at the receiver's maximum of 3.
    function automatic logic [1:0] clip3(input logic [3:0] v);
        logic [1:0] r;
        if (v >= 4'd3) begin
            r = 2'd3;
        end else begin
            r = v[1:0];
        end
        return r;
    endfunction

    // Distance to target and next command; X axis is always closed before Y.
    always_comb begin
        dx_s  = (tx_q >= pos_x_q) ? (tx_q - pos_x_q) : (pos_x_q - tx_q);
        dy_s  = (ty_q >= pos_y_q) ? (ty_q - pos_y_q) : (pos_y_q - ty_q);
        cmd_s = 4'd0;
        if (dx_s != 4'd0) begin
            cmd_s = {clip3(dx_s), (tx_q > pos_x_q) ? 2'b00 : 2'b01};
        end else if (dy_s != 4'd0) begin
            cmd_s = {clip3(dy_s), (ty_q > pos_y_q) ? 2'b11 : 2'b10};
        end else begin
            cmd_s = 4'd0;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    tx_d    = target_x_i;
                    ty_d    = target_y_i;
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                cnt_d = 8'd0;
                if ((dx_s != 4'd0) || (dy_s != 4'd0)) begin
                    y_d     = cmd_s;
                    state_d = S_PULSE_HI;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_PULSE_HI: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_PULSE_LO;
                    // dis never exceeds the remaining distance, so no wrap is possible.
                    case (y_q[1:0])
                        2'b00:   pos_x_d = pos_x_q + {2'b00, y_q[3:2]};
                        2'b01:   pos_x_d = pos_x_q - {2'b00, y_q[3:2]};
                        2'b10:   pos_y_d = pos_y_q - {2'b00, y_q[3:2]};
                        2'b11:   pos_y_d = pos_y_q + {2'b00, y_q[3:2]};
                        default: pos_x_d = pos_x_q;
                    endcase
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_PULSE_LO: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_CALC;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        re_d   = (state_d == S_PULSE_HI);
        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_CALC) || (state_d == S_PULSE_HI) || (state_d == S_PULSE_LO);
    end

    // State and output registers; reset abandons any walk in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            tx_q    <= 4'd0;
            ty_q    <= 4'd0;
            pos_x_q <= 4'd0;
            pos_y_q <= 4'd0;
            y_q     <= 4'd0;
            cnt_q   <= 8'd0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            re_q    <= re_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y_o              = y_q;
    assign rotation_event_o = re_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pos_x_o          = pos_x_q;
    assign pos_y_o          = pos_y_q;

endmodule

// File: tb/tb_grid_path_gen.sv
// Scoreboard bench for grid_path_gen: a walk model queues expected strobes and completions,
// a negedge monitor pops and compares them and polices pulse shape.
module tb_grid_path_gen;

    localparam int HOLD = 1;
    localparam int GAP  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] target_x = 4'd0;
    logic [3:0] target_y = 4'd0;
    logic [3:0] y_o;
    logic       rotation_event_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] pos_x_o;
    logic [3:0] pos_y_o;

    grid_path_gen #(.HOLD(HOLD), .GAP(GAP)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .target_x_i       (target_x),
        .target_y_i       (target_y),
        .y_o              (y_o),
        .rotation_event_o (rotation_event_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .pos_x_o          (pos_x_o),
        .pos_y_o          (pos_y_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_done;
        logic [3:0] y;
        logic [3:0] px;
        logic [3:0] py;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cx = 0, cy = 0;
    logic [3:0] last_y = 4'd0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference walk: close X then Y in steps of min(remaining,3).
    task automatic push_walk(input int tx, input int ty);
        exp_t e;
        int   x = cx, yy = cy, d, s;
        logic [1:0] s2;
        while (x != tx) begin
            d  = (tx > x) ? tx - x : x - tx;
            s  = (d > 3) ? 3 : d;
            s2 = s[1:0];
            e.is_done = 1'b0; e.y = {s2, (tx > x) ? 2'b00 : 2'b01};
            e.px = x[3:0]; e.py = yy[3:0];
            q.push_back(e); last_y = e.y;
            x = (tx > x) ? x + s : x - s;
        end
        while (yy != ty) begin
            d  = (ty > yy) ? ty - yy : yy - ty;
            s  = (d > 3) ? 3 : d;
            s2 = s[1:0];
            e.is_done = 1'b0; e.y = {s2, (ty > yy) ? 2'b11 : 2'b10};
            e.px = x[3:0]; e.py = yy[3:0];
            q.push_back(e); last_y = e.y;
            yy = (ty > yy) ? yy + s : yy - s;
        end
        e.is_done = 1'b1; e.y = last_y; e.px = tx[3:0]; e.py = ty[3:0];
        q.push_back(e);
        cx = tx; cy = ty;
    endtask

    // Monitor: consumes expectations on each strobe rising edge and each done pulse.
    logic       prev_re = 1'b0, seen = 1'b0;
    int         hi_len = 0, lo_len = 0;
    logic [3:0] cur_y = 4'd0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_re = 1'b0; seen = 1'b0; hi_len = 0; lo_len = 0;
        end else begin
            if (rotation_event_o && !prev_re) begin
                if (seen) check("gap_len", 16'(lo_len >= GAP), 16'd1);
                if (q.size() == 0) begin
                    check("unexpected_strobe", {12'd0, y_o}, 16'hFFFF);
                end else begin
                    e = q.pop_front();
                    check("strobe_kind", {15'd0, e.is_done}, 16'd0);
                    check("cmd_y", {12'd0, y_o}, {12'd0, e.y});
                    check("pos_before_cmd", {8'd0, pos_x_o, pos_y_o}, {8'd0, e.px, e.py});
                end
                cur_y = y_o; hi_len = 1;
            end else if (rotation_event_o) begin
                hi_len++;
                check("y_stable_hi", {12'd0, y_o}, {12'd0, cur_y});
            end else if (prev_re) begin
                check("hold_len", 16'(hi_len), 16'(HOLD));
                check("y_stable_lo", {12'd0, y_o}, {12'd0, cur_y});
                lo_len = 1; seen = 1'b1;
            end else begin
                lo_len++;
                if (busy_o && seen) check("y_stable_lo", {12'd0, y_o}, {12'd0, cur_y});
            end
            if (done_o) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 16'd1, 16'd0);
                end else begin
                    e = q.pop_front();
                    check("done_kind", {15'd0, e.is_done}, 16'd1);
                    check("done_pos", {8'd0, pos_x_o, pos_y_o}, {8'd0, e.px, e.py});
                    check("done_y_kept", {12'd0, y_o}, {12'd0, e.y});
                    check("done_busy", {15'd0, busy_o}, 16'd0);
                end
            end
            prev_re = rotation_event_o;
        end
    end

    task automatic run_walk(input int tx, input int ty, input bit tog, input bit lat);
        int n;
        @(negedge clk);
        push_walk(tx, ty);
        target_x = tx[3:0]; target_y = ty[3:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (lat) begin
            check("lat_k", {13'd0, busy_o, rotation_event_o, done_o}, 16'b100);
            @(negedge clk);
            check("lat_k2", {15'd0, rotation_event_o | done_o}, 16'd1);
        end
        for (n = 0; n < 3000; n++) begin
            if (done_o) break;
            if (tog && n >= 1 && n <= 10) begin
                start = 1'($urandom_range(0, 1));
                target_x = 4'($urandom); target_y = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (n >= 3000) check("done_timeout", 16'd0, 16'd1);
        @(negedge clk);
        check("done_pulse", {14'd0, done_o, busy_o}, 16'd0);
    endtask

    initial begin
        int rises, n;
        logic pr;
        @(negedge clk); @(negedge clk);
        check("reset_state", {3'd0, y_o, rotation_event_o, busy_o, done_o, pos_x_o, pos_y_o}, 16'd0);
        rst = 1'b0;

        run_walk(7, 0, 1'b0, 1'b1);
        check("pos_7_0", {8'd0, pos_x_o, pos_y_o}, 16'h0070);
        run_walk(2, 5, 1'b0, 1'b1);
        check("pos_2_5", {8'd0, pos_x_o, pos_y_o}, 16'h0025);
        run_walk(2, 5, 1'b0, 1'b1);
        run_walk((cx < 8) ? 15 : 0, (cy < 8) ? 15 : 0, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_walk($urandom_range(0, 15), $urandom_range(0, 15), 1'b0, 1'b1);
        end

        run_walk(0, 0, 1'b0, 1'b0);
        @(negedge clk);
        push_walk(15, 15);
        target_x = 4'd15; target_y = 4'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rises = 0; pr = 1'b0;
        for (n = 0; n < 200; n++) begin
            if (rotation_event_o && !pr) rises++;
            if (rises == 2) break;
            pr = rotation_event_o;
            @(negedge clk);
        end
        if (n >= 200) check("second_pulse_timeout", 16'd0, 16'd1);
        rst = 1'b1;
        #1;
        check("mid_walk_reset", {3'd0, y_o, rotation_event_o, busy_o, done_o, pos_x_o, pos_y_o}, 16'd0);
        q.delete();
        cx = 0; cy = 0; last_y = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        run_walk(3, 2, 1'b0, 1'b1);
        check("restart_pos", {8'd0, pos_x_o, pos_y_o}, 16'h0032);

        repeat (4) @(negedge clk);
        check("queue_drained", 16'(q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
